// File: rtl/boundary_scan_register.sv
// IEEE 1149.1 style boundary scan register with full 16-state TAP,
// 2-bit instruction register, WIDTH-cell BSR and 1-bit bypass.
module boundary_scan_register #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             TMS,
  input  logic             TDI,
  input  logic [WIDTH-1:0] Data_IN,
  output logic             TDO,
  output logic             TDO_EN,
  output logic [WIDTH-1:0] Data_OUT,
  output logic [3:0]       TapState
);

  typedef enum logic [3:0] {
    TLR   = 4'd0,
    RTI   = 4'd1,
    SELDR = 4'd2,
    CAPDR = 4'd3,
    SHDR  = 4'd4,
    EX1DR = 4'd5,
    PAUDR = 4'd6,
    EX2DR = 4'd7,
    UPDDR = 4'd8,
    SELIR = 4'd9,
    CAPIR = 4'd10,
    SHIR  = 4'd11,
    EX1IR = 4'd12,
    PAUIR = 4'd13,
    EX2IR = 4'd14,
    UPDIR = 4'd15
  } tap_e;

  tap_e             state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic [1:0]       ir_q, ir_d;
  logic [1:0]       irsr_q, irsr_d;
  logic             byp_q, byp_d;
  logic             bsr_sel;

  // EXTEST (00) and SAMPLE (01) select the BSR; 1x selects bypass
  assign bsr_sel = ~ir_q[1];

  // TAP next-state table driven by TMS
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = TMS ? TLR   : RTI;
      RTI:     state_d = TMS ? SELDR : RTI;
      SELDR:   state_d = TMS ? SELIR : CAPDR;
      CAPDR:   state_d = TMS ? EX1DR : SHDR;
      SHDR:    state_d = TMS ? EX1DR : SHDR;
      EX1DR:   state_d = TMS ? UPDDR : PAUDR;
      PAUDR:   state_d = TMS ? EX2DR : PAUDR;
      EX2DR:   state_d = TMS ? UPDDR : SHDR;
      UPDDR:   state_d = TMS ? SELDR : RTI;
      SELIR:   state_d = TMS ? TLR   : CAPIR;
      CAPIR:   state_d = TMS ? EX1IR : SHIR;
      SHIR:    state_d = TMS ? EX1IR : SHIR;
      EX1IR:   state_d = TMS ? UPDIR : PAUIR;
      PAUIR:   state_d = TMS ? EX2IR : PAUIR;
      EX2IR:   state_d = TMS ? UPDIR : SHIR;
      UPDIR:   state_d = TMS ? SELDR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Capture/shift/update actions; every other state holds
  always_comb begin
    sr_d   = sr_q;
    upd_d  = upd_q;
    byp_d  = byp_q;
    ir_d   = ir_q;
    irsr_d = irsr_q;
    case (state_q)
      CAPDR: begin
        if (bsr_sel) sr_d = Data_IN;
        else         byp_d = 1'b0;
      end
      SHDR: begin
        if (bsr_sel) sr_d = {TDI, sr_q[WIDTH-1:1]};
        else         byp_d = TDI;
      end
      UPDDR: begin
        if (bsr_sel) upd_d = sr_q;
      end
      CAPIR:   irsr_d = 2'b01;
      SHIR:    irsr_d = {TDI, irsr_q[1]};
      UPDIR:   ir_d = irsr_q;
      default: ;
    endcase
    // Landing in TLR via TMS forces BYPASS; data registers keep values
    if (state_d == TLR) ir_d = 2'b11;
  end

  // State and register update with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= TLR;
      sr_q    <= '0;
      upd_q   <= '0;
      byp_q   <= 1'b0;
      ir_q    <= 2'b11;
      irsr_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      upd_q   <= upd_d;
      byp_q   <= byp_d;
      ir_q    <= ir_d;
      irsr_q  <= irsr_d;
    end
  end

  // Serial output mux and pin drive
  always_comb begin
    TDO = 1'b0;
    if (state_q == SHDR) TDO = bsr_sel ? sr_q[0] : byp_q;
    else if (state_q == SHIR) TDO = irsr_q[0];
  end

  assign TDO_EN   = (state_q == SHDR) || (state_q == SHIR);
  assign Data_OUT = (ir_q == 2'b00) ? upd_q : Data_IN;
  assign TapState = state_q;

endmodule

// File: tb/tb_boundary_scan_register.sv
// Self-checking bench for boundary_scan_register (WIDTH=8):
// vector table plus hand sequences through a scoreboard queue.
module tb_boundary_scan_register;

  localparam int W = 8;

  localparam logic [3:0] S_TLR = 4'd0, S_RTI = 4'd1, S_SELDR = 4'd2,
    S_CAPDR = 4'd3, S_SHDR = 4'd4, S_EX1DR = 4'd5, S_PAUDR = 4'd6,
    S_EX2DR = 4'd7, S_UPDDR = 4'd8, S_SELIR = 4'd9, S_CAPIR = 4'd10,
    S_SHIR = 4'd11, S_EX1IR = 4'd12, S_UPDIR = 4'd15;

  logic         clk = 1'b0;
  logic         Reset, TMS, TDI;
  logic [W-1:0] Data_IN, Data_OUT;
  logic         TDO, TDO_EN;
  logic [3:0]   TapState;

  boundary_scan_register #(.WIDTH(W)) dut (
    .Clock(clk), .Reset(Reset), .TMS(TMS), .TDI(TDI),
    .Data_IN(Data_IN), .TDO(TDO), .TDO_EN(TDO_EN),
    .Data_OUT(Data_OUT), .TapState(TapState)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   st;
    logic         tdo;
    logic         en;
    logic [W-1:0] dout;
  } exp_t;

  typedef struct {
    logic         tms;
    logic         tdi;
    logic [W-1:0] din;
    logic [3:0]   st;
    logic         tdo;
    logic         en;
    logic [W-1:0] dout;
  } vec_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  logic         rst_nxt = 1'b0;
  logic [1:0]   ir_m = 2'b11;
  logic [W-1:0] upd_m = '0;

  function automatic logic [W-1:0] dx(input logic [W-1:0] din);
    return (ir_m == 2'b00) ? upd_m : din;
  endfunction

  task automatic chk(input string nm, input string f,
                     input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", nm, f, act, exp);
    end
  endtask

  // Drive one cycle at negedge, queue expectation, compare before posedge
  task automatic cyc(input logic tms, input logic tdi,
                     input logic [W-1:0] din, input logic [3:0] st,
                     input logic tdo, input logic en,
                     input logic [W-1:0] dout, input string nm);
    exp_t e;
    @(negedge clk);
    Reset = rst_nxt;
    TMS = tms;
    TDI = tdi;
    Data_IN = din;
    e.st = st;
    e.tdo = tdo;
    e.en = en;
    e.dout = dout;
    sbq.push_back(e);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.queue got empty want entry", nm);
    end else begin
      e = sbq.pop_front();
      chk(nm, "state", {4'b0, TapState}, {4'b0, e.st});
      chk(nm, "tdo", {7'b0, TDO}, {7'b0, e.tdo});
      chk(nm, "tdo_en", {7'b0, TDO_EN}, {7'b0, e.en});
      chk(nm, "dout", Data_OUT, e.dout);
    end
  endtask

  // From RTI: load IR with v and return to RTI
  task automatic load_ir(input logic [1:0] v, input logic [W-1:0] din);
    cyc(1, 0, din, S_RTI, 0, 0, dx(din), "li_rti");
    cyc(1, 0, din, S_SELDR, 0, 0, dx(din), "li_seldr");
    cyc(0, 0, din, S_SELIR, 0, 0, dx(din), "li_selir");
    cyc(0, 0, din, S_CAPIR, 0, 0, dx(din), "li_capir");
    cyc(0, v[0], din, S_SHIR, 1, 1, dx(din), "li_sh0");
    cyc(1, v[1], din, S_SHIR, 0, 1, dx(din), "li_sh1");
    cyc(1, 0, din, S_EX1IR, 0, 0, dx(din), "li_ex1");
    cyc(0, 0, din, S_UPDIR, 0, 0, dx(din), "li_upd");
    ir_m = v;
  endtask

  initial begin
    vec_t         tbl[10];
    logic [W-1:0] pat;
    logic [W-1:0] cap;

    tbl[0] = '{0, 0, 8'h5A, S_TLR,   0, 0, 8'h5A};
    tbl[1] = '{1, 0, 8'h5A, S_RTI,   0, 0, 8'h5A};
    tbl[2] = '{0, 0, 8'h5A, S_SELDR, 0, 0, 8'h5A};
    tbl[3] = '{0, 0, 8'h5A, S_CAPDR, 0, 0, 8'h5A};
    tbl[4] = '{1, 1, 8'hC3, S_SHDR,  0, 1, 8'hC3};
    tbl[5] = '{1, 0, 8'hC3, S_EX1DR, 0, 0, 8'hC3};
    tbl[6] = '{1, 0, 8'hC3, S_UPDDR, 0, 0, 8'hC3};
    tbl[7] = '{1, 0, 8'hC3, S_SELDR, 0, 0, 8'hC3};
    tbl[8] = '{1, 0, 8'hC3, S_SELIR, 0, 0, 8'hC3};
    tbl[9] = '{1, 0, 8'h77, S_TLR,   0, 0, 8'h77};

    Reset = 1'b1;
    TMS = 1'b1;
    TDI = 1'b0;
    Data_IN = 8'h00;
    @(negedge clk);
    @(negedge clk);

    // Reset state, then five TMS=1 from ShDR back to TLR
    for (int i = 0; i < 10; i++)
      cyc(tbl[i].tms, tbl[i].tdi, tbl[i].din, tbl[i].st,
          tbl[i].tdo, tbl[i].en, tbl[i].dout, $sformatf("vec%0d", i));

    // IR scan of 00: TDO shows 1 then 0, IR becomes EXTEST
    cyc(0, 0, 8'h21, S_TLR, 0, 0, 8'h21, "ir_tlr");
    load_ir(2'b00, 8'h42);
    cyc(0, 0, 8'h11, S_RTI, 0, 0, 8'h00, "extest_rti");

    // SAMPLE: capture A5, shift out LSB first while shifting in 3C
    load_ir(2'b01, 8'h11);
    cap = 8'hA5;
    pat = 8'h3C;
    cyc(1, 0, 8'hA5, S_RTI, 0, 0, 8'hA5, "smp_rti");
    cyc(0, 0, 8'hA5, S_SELDR, 0, 0, 8'hA5, "smp_sel");
    cyc(0, 0, 8'hA5, S_CAPDR, 0, 0, 8'hA5, "smp_cap");
    for (int i = 0; i < 8; i++)
      cyc(i == 7, pat[i], 8'(i * 17), S_SHDR, cap[i], 1,
          8'(i * 17), $sformatf("smp_sh%0d", i));
    cyc(1, 0, 8'h90, S_EX1DR, 0, 0, 8'h90, "smp_ex1");
    cyc(0, 0, 8'h91, S_UPDDR, 0, 0, 8'h91, "smp_upd");
    upd_m = 8'h3C;

    // EXTEST drives 3C regardless of Data_IN, through Pause and RTI
    load_ir(2'b00, 8'h99);
    cyc(0, 0, 8'hFF, S_RTI, 0, 0, 8'h3C, "ext_rti0");
    cyc(1, 0, 8'h00, S_RTI, 0, 0, 8'h3C, "ext_rti1");
    cyc(0, 0, 8'h3C, S_SELDR, 0, 0, 8'h3C, "ext_sel");
    cyc(1, 0, 8'h3C, S_CAPDR, 0, 0, 8'h3C, "ext_cap");
    cyc(0, 0, 8'h55, S_EX1DR, 0, 0, 8'h3C, "ext_ex1");
    cyc(0, 0, 8'hAA, S_PAUDR, 0, 0, 8'h3C, "ext_pau0");
    cyc(1, 0, 8'h55, S_PAUDR, 0, 0, 8'h3C, "ext_pau1");
    cyc(1, 0, 8'hAA, S_EX2DR, 0, 0, 8'h3C, "ext_ex2");
    cyc(0, 0, 8'h12, S_UPDDR, 0, 0, 8'h3C, "ext_upd");
    cyc(1, 0, 8'h34, S_RTI, 0, 0, 8'h3C, "ext_rti2");

    // TMS path into TLR sets BYPASS but keeps update register
    cyc(1, 0, 8'h34, S_SELDR, 0, 0, 8'h3C, "tlr_seldr");
    cyc(1, 0, 8'h34, S_SELIR, 0, 0, 8'h3C, "tlr_selir");
    ir_m = 2'b11;
    cyc(0, 0, 8'h5F, S_TLR, 0, 0, 8'h5F, "tlr_in");
    load_ir(2'b00, 8'h66);
    cyc(0, 0, 8'hC0, S_RTI, 0, 0, 8'h3C, "tlr_hold");

    // BYPASS: one-cycle delay, captured 0 first
    load_ir(2'b10, 8'h66);
    cyc(1, 0, 8'hD1, S_RTI, 0, 0, 8'hD1, "byp_rti");
    cyc(0, 0, 8'hD1, S_SELDR, 0, 0, 8'hD1, "byp_sel");
    cyc(0, 0, 8'hD1, S_CAPDR, 0, 0, 8'hD1, "byp_cap");
    cyc(0, 1, 8'hD2, S_SHDR, 0, 1, 8'hD2, "byp_sh0");
    cyc(0, 1, 8'hD3, S_SHDR, 1, 1, 8'hD3, "byp_sh1");
    cyc(1, 0, 8'hD4, S_SHDR, 1, 1, 8'hD4, "byp_sh2");
    cyc(1, 0, 8'hD5, S_EX1DR, 0, 0, 8'hD5, "byp_ex1");
    cyc(0, 0, 8'hD6, S_UPDDR, 0, 0, 8'hD6, "byp_upd");
    load_ir(2'b00, 8'h01);
    cyc(0, 0, 8'h02, S_RTI, 0, 0, 8'h3C, "byp_hold");

    // Reset during ShDR under EXTEST aborts without update
    cyc(1, 0, 8'h0F, S_RTI, 0, 0, 8'h3C, "rst_rti");
    cyc(0, 0, 8'h0F, S_SELDR, 0, 0, 8'h3C, "rst_sel");
    cyc(0, 0, 8'h0F, S_CAPDR, 0, 0, 8'h3C, "rst_cap");
    cyc(0, 0, 8'h10, S_SHDR, 1, 1, 8'h3C, "rst_sh0");
    cyc(0, 0, 8'h20, S_SHDR, 1, 1, 8'h3C, "rst_sh1");
    cyc(0, 0, 8'h30, S_SHDR, 1, 1, 8'h3C, "rst_sh2");
    rst_nxt = 1'b1;
    cyc(0, 0, 8'h40, S_SHDR, 1, 1, 8'h3C, "rst_sh3");
    rst_nxt = 1'b0;
    ir_m = 2'b11;
    upd_m = '0;
    cyc(0, 0, 8'hE7, S_TLR, 0, 0, 8'hE7, "rst_tlr");
    load_ir(2'b00, 8'h5C);
    cyc(0, 0, 8'hAA, S_RTI, 0, 0, 8'h00, "rst_upd0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
